// File: rtl/finn_rtl_krnl_example_pkg.sv
// Shared types and constants for the example kernel read-burst controller.
package finn_rtl_krnl_example_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reference build: 32-bit data, 16-beat bursts
  localparam int BYTES_PER_BEAT = 32 / 8;
  localparam int BURST_LEN_LOG2 = 4;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/finn_rtl_krnl_example_counter.sv
// Up/down counter with zero flag; rst reloads the counter with init.
module finn_rtl_krnl_example_counter
  import finn_rtl_krnl_example_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic [WIDTH-1:0] init,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rst) begin
      cnt <= init;
    end else if (up && !dn) begin
      cnt <= cnt + WIDTH'(1);
    end else if (dn && !up) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/finn_rtl_krnl_example_rd_burst_ctrl.sv
// AXI read-burst controller: splits a byte transfer into bursts and forwards R beats to a stream.
module finn_rtl_krnl_example_rd_burst_ctrl
  import finn_rtl_krnl_example_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 16,
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic                      ctrl_start,
  output logic                      ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                      m_axi_rlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tlast
);

  localparam int BPB         = bytes_per_beat(C_DATA_WIDTH);
  localparam int BEAT_SHIFT  = $clog2(BPB);
  localparam int BURST_SHIFT = $clog2(C_BURST_LEN);
  localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int LW          = C_LENGTH_WIDTH;
  localparam logic [LW-1:0]           BURST_MASK  = LW'(C_BURST_LEN - 1);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BPB);
  localparam logic [7:0]              FULL_ARLEN  = 8'(C_BURST_LEN - 1);

  state_t                  state;
  logic                    done_q;
  logic [LW-1:0]           beats_left;
  logic [LW-1:0]           total_beats;
  logic [LW-1:0]           tail_beats;
  logic [LW-1:0]           total_bursts;
  logic [LW-1:0]           bursts_left;
  logic                    bursts_zero;
  logic [OUT_W-1:0]        outstanding;
  logic                    out_zero;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]              last_arlen;
  logic                    in_run;
  logic                    start_accept;
  logic                    cnt_rst;
  logic                    ar_hs;
  logic                    r_hs;
  logic                    rlast_hs;

  assign total_beats  = ctrl_xfer_size_in_bytes >> BEAT_SHIFT;
  assign tail_beats   = total_beats & BURST_MASK;
  assign total_bursts = (total_beats >> BURST_SHIFT) + ((tail_beats != '0) ? LW'(1) : LW'(0));

  assign in_run       = (state == ST_RUN);
  assign start_accept = (state == ST_IDLE) && ctrl_start;
  assign cnt_rst      = ~areset_n | start_accept;

  // Outstanding can only fall while arvalid waits, so arvalid/araddr/arlen stay stable
  assign m_axi_arvalid = in_run && !bursts_zero && (outstanding < OUT_W'(C_MAX_OUTSTANDING));
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = (bursts_left == LW'(1)) ? last_arlen : FULL_ARLEN;
  assign ar_hs         = m_axi_arvalid && m_axi_arready;

  assign m_axi_rready  = in_run && m_axis_tready;
  assign m_axis_tvalid = in_run && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = m_axis_tvalid && (beats_left == LW'(1));
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign rlast_hs      = r_hs && m_axi_rlast && !out_zero;

  assign ctrl_done = done_q;

  finn_rtl_krnl_example_counter #(.WIDTH(OUT_W)) u_outstanding (
    .clk  (aclk),
    .rst_n(areset_n),
    .rst  (cnt_rst),
    .init ('0),
    .up   (ar_hs),
    .dn   (rlast_hs),
    .cnt  (outstanding),
    .zero (out_zero)
  );

  finn_rtl_krnl_example_counter #(.WIDTH(LW)) u_bursts_left (
    .clk  (aclk),
    .rst_n(areset_n),
    .rst  (cnt_rst),
    .init (total_bursts),
    .up   (1'b0),
    .dn   (ar_hs),
    .cnt  (bursts_left),
    .zero (bursts_zero)
  );

  always_ff @(posedge aclk) begin
    if (start_accept) begin
      addr_q     <= ctrl_addr_offset;
      last_arlen <= (tail_beats == '0) ? FULL_ARLEN : 8'(tail_beats - LW'(1));
    end else if (ar_hs) begin
      addr_q <= addr_q + BURST_BYTES;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_IDLE;
      beats_left <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ctrl_start) begin
            beats_left <= total_beats;
            if (total_beats == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (r_hs) begin
            beats_left <= beats_left - LW'(1);
            if ((beats_left == LW'(1)) && bursts_zero) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_example_rd_burst_ctrl.sv
// Directed and randomized bench for the read-burst controller with a reactive AXI memory model.
module tb_finn_rtl_krnl_example_rd_burst_ctrl;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int LW  = 32;
  localparam int BL  = 16;
  localparam int MO  = 2;
  localparam int BPB = DW / 8;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          ctrl_start = 1'b0;
  logic          ctrl_done;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [LW-1:0] ctrl_xfer_size_in_bytes = '0;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic          m_axi_rlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  finn_rtl_krnl_example_rd_burst_ctrl #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_LENGTH_WIDTH(LW),
    .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [63:0] addr; logic [7:0] len; int cyc; } ar_t;
  typedef struct { logic [31:0] data; logic last; int cyc; } beat_t;

  // Bus behaviour knobs: 0 never/withheld, 1 always, 2 random; t_mode 1 is the 1,0,0,1 pattern
  int ar_mode = 0;
  int r_mode  = 0;
  int t_mode  = 0;

  ar_t   obs_ar[$];
  beat_t obs_beats[$];
  int    done_cyc[$];
  int    rlast_cyc[$];
  ar_t   slave_q[$];
  int    start_cyc = -1;
  int    viol = 0;
  int    cyc = 0;
  int    beat_idx = 0;
  int    out_model = 0;
  int    tvalid_cnt = 0;
  int    arvalid_cnt = 0;
  int    total = 0;
  int    bad = 0;
  bit    hs_ar = 0, hs_r = 0, hs_s = 0, ar_pend = 0;
  ar_t   last_ar, hold_ar;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // AXI memory model plus protocol monitor; drives at negedge, samples 1 unit before posedge
  always begin
    @(negedge aclk);
    cyc++;
    if (!areset_n) begin
      slave_q.delete();
      beat_idx  = 0;
      out_model = 0;
    end else begin
      if (hs_ar) slave_q.push_back(last_ar);
      if (hs_r && slave_q.size() > 0) begin
        if (beat_idx == int'(slave_q[0].len)) begin
          void'(slave_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
    end
    m_axi_arready = (ar_mode == 1) ? 1'b1 : (ar_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (slave_q.size() > 0 && (r_mode == 1 || (r_mode == 2 && $urandom_range(0, 1) == 1))) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = mem_data(slave_q[0].addr + 64'(beat_idx * BPB));
      m_axi_rlast  = (beat_idx == int'(slave_q[0].len));
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
    end
    case (t_mode)
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
    #4;
    hs_ar = m_axi_arvalid && m_axi_arready;
    hs_r  = m_axi_rvalid && m_axi_rready;
    hs_s  = m_axis_tvalid && m_axis_tready;
    if (areset_n && ar_pend &&
        !(m_axi_arvalid && m_axi_araddr == hold_ar.addr && m_axi_arlen == hold_ar.len)) viol++;
    ar_pend = m_axi_arvalid && !m_axi_arready;
    hold_ar = '{m_axi_araddr, m_axi_arlen, cyc};
    if (hs_ar) begin
      last_ar = '{m_axi_araddr, m_axi_arlen, cyc};
      obs_ar.push_back(last_ar);
      out_model++;
    end
    if (hs_r != hs_s) viol++;
    if (m_axis_tvalid && (!m_axi_rvalid || m_axi_rready !== m_axis_tready ||
                          m_axis_tdata !== m_axi_rdata)) viol++;
    if (hs_s) obs_beats.push_back('{m_axis_tdata, m_axis_tlast, cyc});
    if (hs_r && m_axi_rlast) begin
      rlast_cyc.push_back(cyc);
      out_model--;
    end
    if (out_model > MO) viol++;
    if (m_axis_tvalid) tvalid_cnt++;
    if (m_axi_arvalid) arvalid_cnt++;
    if (ctrl_done) done_cyc.push_back(cyc);
    if (ctrl_start) start_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_ar.delete();
    obs_beats.delete();
    done_cyc.delete();
    rlast_cyc.delete();
    tvalid_cnt  = 0;
    arvalid_cnt = 0;
    viol        = 0;
    start_cyc   = -1;
  endtask

  task automatic start_xfer(input logic [63:0] addr, input int size);
    @(negedge aclk);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = LW'(size);
    ctrl_start              = 1'b1;
    @(negedge aclk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_cyc.size() > 0) break;
      @(negedge aclk);
    end
    check({nm, " done_seen"}, 64'(done_cyc.size() > 0), 64'd1);
    repeat (6) @(negedge aclk);
  endtask

  // Reference: bursts of BL beats from the start address, last one shorter; beat i reads addr+i*BPB
  task automatic check_xfer(input string nm, input logic [63:0] addr, input int size);
    int beats, nbursts, n;
    beats   = size / BPB;
    nbursts = (beats + BL - 1) / BL;
    check({nm, " ar_count"}, 64'(obs_ar.size()), 64'(nbursts));
    n = (obs_ar.size() < nbursts) ? obs_ar.size() : nbursts;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s ar%0d_addr", nm, k), obs_ar[k].addr, addr + 64'(k * BL * BPB));
      check($sformatf("%s ar%0d_len", nm, k), 64'(obs_ar[k].len),
            (k == nbursts - 1) ? 64'(beats - k * BL - 1) : 64'(BL - 1));
    end
    check({nm, " beat_count"}, 64'(obs_beats.size()), 64'(beats));
    n = (obs_beats.size() < beats) ? obs_beats.size() : beats;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s beat%0d_data", nm, i), 64'(obs_beats[i].data),
            64'(mem_data(addr + 64'(i * BPB))));
      check($sformatf("%s beat%0d_last", nm, i), 64'(obs_beats[i].last), 64'(i == beats - 1));
    end
    check({nm, " done_pulses"}, 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) begin
      if (beats > 0 && obs_beats.size() > 0)
        check({nm, " done_after_last"}, 64'(done_cyc[0]),
              64'(obs_beats[obs_beats.size() - 1].cyc + 1));
      else if (beats == 0)
        check({nm, " done_after_start"}, 64'(done_cyc[0]), 64'(start_cyc + 1));
    end
    check({nm, " protocol_violations"}, 64'(viol), 64'd0);
  endtask

  initial begin
    logic [63:0] raddr;
    int          rsize;

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    check("rst arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst rready", 64'(m_axi_rready), 64'd0);
    check("rst tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst done", 64'(ctrl_done), 64'd0);
    @(negedge aclk);
    areset_n = 1'b1;

    // Scenario 1: 256 B, always ready
    clear_obs(); ar_mode = 1; r_mode = 1; t_mode = 0;
    start_xfer(64'h1000, 256);
    wait_done("s1", 500);
    check_xfer("s1", 64'h1000, 256);

    // Scenario 2: 72 B, short tail burst
    clear_obs();
    start_xfer(64'h2000, 72);
    wait_done("s2", 500);
    check_xfer("s2", 64'h2000, 72);

    // Scenario 3: outstanding limit with R withheld
    clear_obs(); r_mode = 0;
    start_xfer(64'h3000, 256);
    repeat (20) @(negedge aclk);
    check("s3 ar_held_count", 64'(obs_ar.size()), 64'd2);
    check("s3 arvalid_low", 64'(m_axi_arvalid), 64'd0);
    r_mode = 1;
    wait_done("s3", 800);
    if (obs_ar.size() > 2 && rlast_cyc.size() > 0)
      check("s3 third_ar_after_rlast", 64'(obs_ar[2].cyc > rlast_cyc[0]), 64'd1);
    else
      check("s3 third_ar_present", 64'(obs_ar.size()), 64'd4);
    check_xfer("s3", 64'h3000, 256);

    // Scenario 4: tready pattern 1,0,0,1
    clear_obs(); t_mode = 1;
    start_xfer(64'h5000, 100);
    wait_done("s4", 800);
    check_xfer("s4", 64'h5000, 100);
    t_mode = 0;

    // Scenario 5: zero size, then a start during RUN
    clear_obs();
    start_xfer(64'h6000, 0);
    wait_done("s5a", 20);
    check_xfer("s5a", 64'h6000, 0);
    check("s5a tvalid_cycles", 64'(tvalid_cnt), 64'd0);
    check("s5a arvalid_cycles", 64'(arvalid_cnt), 64'd0);
    clear_obs();
    start_xfer(64'h7000, 64);
    repeat (3) @(negedge aclk);
    ctrl_addr_offset = 64'h9000; ctrl_xfer_size_in_bytes = LW'(128); ctrl_start = 1'b1;
    @(negedge aclk);
    ctrl_start = 1'b0;
    wait_done("s5b", 500);
    check_xfer("s5b", 64'h7000, 64);

    // Scenario 6: reset mid-transfer
    clear_obs(); r_mode = 0;
    start_xfer(64'h8000, 256);
    for (int i = 0; i < 50 && obs_ar.size() < 2; i++) @(negedge aclk);
    check("s6 two_ar", 64'(obs_ar.size()), 64'd2);
    ar_mode = 0; r_mode = 1;
    for (int i = 0; i < 100 && obs_beats.size() < 18; i++) @(negedge aclk);
    check("s6 beats_before_rst", 64'(obs_beats.size() >= 18), 64'd1);
    #2;
    check("s6 pre arvalid", 64'(m_axi_arvalid), 64'd1);
    check("s6 pre tvalid", 64'(m_axis_tvalid), 64'd1);
    areset_n = 1'b0;
    #1;
    check("s6 rst arvalid", 64'(m_axi_arvalid), 64'd0);
    check("s6 rst rready", 64'(m_axi_rready), 64'd0);
    check("s6 rst tvalid", 64'(m_axis_tvalid), 64'd0);
    check("s6 rst tlast", 64'(m_axis_tlast), 64'd0);
    check("s6 rst done", 64'(ctrl_done), 64'd0);
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    clear_obs(); ar_mode = 1;
    repeat (20) @(negedge aclk);
    check("s6 no_ar_after_rst", 64'(obs_ar.size()), 64'd0);
    check("s6 no_arvalid_after_rst", 64'(arvalid_cnt), 64'd0);
    check("s6 no_done_after_rst", 64'(done_cyc.size()), 64'd0);

    // Randomized transfers with random back-pressure
    for (int t = 0; t < 8; t++) begin
      clear_obs();
      ar_mode = $urandom_range(1, 2);
      r_mode  = $urandom_range(1, 2);
      t_mode  = $urandom_range(0, 2);
      rsize   = $urandom_range(0, 70) * BPB;
      raddr   = 64'($urandom_range(0, 32'h00FF_FFFF)) << 2;
      start_xfer(raddr, rsize);
      wait_done($sformatf("rnd%0d", t), 3000);
      check_xfer($sformatf("rnd%0d", t), raddr, rsize);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
